switch_input_reader: RTL and testbench

//  User-input end of the board I/O path; the counterpart of the 7-segment output driver.
//  On a CPU read request it waits for a debounced press of the confirm button.
//  It then latches the synchronized DIP-switch value and returns it with a 1-cycle valid pulse.

---
 rtl/switch_input_reader_pkg.sv | 17 +
 rtl/switch_input_reader_button_debouncer.sv | 62 ++++++
 rtl/switch_input_reader.sv | 105 ++++++++++
 tb/tb_switch_input_reader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_input_reader_pkg.sv
// Shared definitions for the board input path: FSM state encoding and
// the default debounce length used when no override is given.
`timescale 1ns/1ps
package switch_input_reader_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_REL   = 2'd1,
        WAIT_PRESS = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Short default keeps simulation fast; the board top overrides it
    // with 2_000_000 (20 ms at 100 MHz).
    localparam int DEB_CYCLES_DEFAULT = 20;

endpackage

// File: rtl/switch_input_reader_button_debouncer.sv
// Confirm-button conditioning: 2-flop synchronizer, stable-run debounce
// counter and rising-edge detect on the debounced level.
`timescale 1ns/1ps
module switch_input_reader_button_debouncer #(
    parameter int DEB_CYCLES = 20,
    parameter int CNT_W      = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    logic [CNT_W-1:0] cnt;
    logic             level_d;

    // Bring the raw pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync      <= sync_meta;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive differing samples;
    // any sample agreeing with the current level restarts the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync != level) begin
            if (cnt == CNT_LAST) begin
                level <= sync;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // One-cycle delayed level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d;

endmodule

// File: rtl/switch_input_reader.sv
// CPU-facing switch reader: on a read request, waits for a fresh debounced
// press of the confirm button, then captures the synchronized DIP switches.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  IDLE       | no request outstanding; rd_req sampled here only
//  WAIT_REL   | request taken while button already held; wait for release
//  WAIT_PRESS | waiting for a debounced rising edge; capture on it
//  DONE       | capture complete; rd_valid fires on the way back to IDLE
`timescale 1ns/1ps
module switch_input_reader
    import switch_input_reader_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int CNT_W      = 21
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_confirm,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_s;
    logic              btn_db;
    logic              btn_rise;
    logic              capture;
    state_t            state;
    state_t            state_next;

    // Switches are static in normal use, so a plain 2-flop bus sync suffices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end

    switch_input_reader_button_debouncer #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_confirm),
        .level (btn_db),
        .rise  (btn_rise)
    );

    // State register plus registered outputs derived from it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_next;
            busy     <= (state_next != IDLE);
            rd_valid <= (state == DONE);
            if (capture) begin
                rd_data <= sw_s;
            end
        end
    end

    // Next-state decode; a held button must be released before it can count.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    state_next = btn_db ? WAIT_REL : WAIT_PRESS;
                end
            end
            WAIT_REL: begin
                if (!btn_db) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                if (btn_rise) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_input_reader.sv
// Bench for switch_input_reader with a short debounce (4 cycles): directed
// scenarios with hand-computed expectations, then random stimulus, all
// compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_switch_input_reader;

    localparam int DATA_W = 16;
    localparam int DEB    = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] sw = '0;
    logic              btn = 1'b0;
    logic              rd_req = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    switch_input_reader #(
        .DATA_W     (DATA_W),
        .DEB_CYCLES (DEB),
        .CNT_W      (21)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw          (sw),
        .btn_confirm (btn),
        .rd_req      (rd_req),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Debounced level flips once the last DEB synchronized samples all
    // disagree with it. Request phase: 0 none, 1 needs release,
    // 2 needs press, 3 captured.
    logic              m_btn1, m_btn2, m_db, m_db_d, m_valid;
    logic [DATA_W-1:0] m_sw1, m_sw2, m_data;
    logic [DEB-1:0]    m_hist;
    int                m_phase;
    logic [DEB-1:0]    m_nh;
    logic              m_flip;
    logic              m_busy;

    assign m_nh   = {m_hist[DEB-2:0], m_btn2};
    assign m_flip = (m_nh == {DEB{~m_db}});
    assign m_busy = (m_phase != 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_btn1 <= 1'b0; m_btn2 <= 1'b0; m_db <= 1'b0; m_db_d <= 1'b0;
            m_valid <= 1'b0; m_sw1 <= '0; m_sw2 <= '0; m_data <= '0;
            m_hist <= '0; m_phase <= 0;
        end else begin
            m_valid <= (m_phase == 3);
            case (m_phase)
                0: if (rd_req) m_phase <= m_db ? 1 : 2;
                1: if (!m_db) m_phase <= 2;
                2: if (m_db && !m_db_d) begin
                       m_data  <= m_sw2;
                       m_phase <= 3;
                   end
                default: m_phase <= 0;
            endcase
            m_hist <= m_nh;
            if (m_flip) m_db <= ~m_db;
            m_db_d <= m_db;
            m_btn2 <= m_btn1; m_btn1 <= btn;
            m_sw2  <= m_sw1;  m_sw1  <= sw;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("busy",     32'(busy),     32'(m_busy));
        check("rd_data",  32'(rd_data),  32'(m_data));
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req_pulse();
        @(negedge clk) rd_req = 1'b1;
        @(negedge clk) rd_req = 1'b0;
    endtask

    // Observe n rising edges; k=1 is the first edge after the call.
    task automatic watch(input int n, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (rd_valid) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
    endtask

    int f, p, f2, p2, bounce_pulses, run;

    initial begin
        // Reset state
        cyc(3);
        check("reset_rd_data", 32'(rd_data), 32'h0);
        check("reset_rd_valid", 32'(rd_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc(3);

        // Basic read
        sw = 16'hA5C3;
        req_pulse();
        cyc(2);
        check("basic_busy", 32'(busy), 32'h1);
        btn = 1'b1;
        watch(10, f, p);
        btn = 1'b0;
        watch(6, f2, p2);
        check("basic_latency", 32'(f), 32'd8);
        check("basic_pulses", 32'(p + p2), 32'd1);
        check("basic_data", 32'(rd_data), 32'hA5C3);
        cyc(4);

        // Bounce
        sw = 16'h3C3C;
        req_pulse();
        bounce_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btn = ((i / 2) % 2 == 0);
            if (rd_valid) bounce_pulses++;
        end
        @(negedge clk) btn = 1'b1;
        watch(12, f, p);
        check("bounce_latency", 32'(f), 32'd8);
        check("bounce_pulses", 32'(p + bounce_pulses), 32'd1);
        check("bounce_data", 32'(rd_data), 32'h3C3C);
        btn = 1'b0;
        cyc(8);

        // Held button
        @(negedge clk) btn = 1'b1;
        cyc(10);
        sw = 16'h00FF;
        req_pulse();
        watch(15, f, p);
        check("held_no_capture", 32'(p), 32'd0);
        check("held_busy", 32'(busy), 32'h1);
        btn = 1'b0;
        cyc(10);
        check("held_rel_busy", 32'(busy), 32'h1);
        btn = 1'b1;
        watch(12, f, p);
        check("held_pulses", 32'(p), 32'd1);
        check("held_latency", 32'(f), 32'd8);
        check("held_data", 32'(rd_data), 32'h00FF);
        btn = 1'b0;
        cyc(8);

        // Ignore and hold
        sw = 16'h5A5A;
        req_pulse();
        cyc(2);
        req_pulse();
        btn = 1'b1;
        watch(9, f, p);
        sw = 16'h1234;
        watch(12, f2, p2);
        check("ignore_pulses", 32'(p + p2), 32'd1);
        check("ignore_latency", 32'(f), 32'd8);
        btn = 1'b0;
        cyc(8);
        check("hold_data", 32'(rd_data), 32'h5A5A);
        check("hold_idle", 32'(busy), 32'h0);

        // Abort by reset mid-wait, asserted at a random point in the cycle
        sw = 16'hBEEF;
        req_pulse();
        cyc(3);
        check("abort_busy_before", 32'(busy), 32'h1);
        @(posedge clk);
        #($urandom_range(1, 8));
        rst_n = 1'b0;
        #1;
        check("abort_rd_data", 32'(rd_data), 32'h0);
        check("abort_rd_valid", 32'(rd_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        @(negedge clk) btn = 1'b1;
        watch(14, f, p);
        check("abort_no_valid", 32'(p), 32'd0);
        check("abort_idle", 32'(busy), 32'h0);
        check("abort_data", 32'(rd_data), 32'h0);
        btn = 1'b0;
        cyc(8);

        // Random stimulus against the model
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (run == 0) begin
                btn = 1'($urandom_range(0, 1));
                run = $urandom_range(1, 12);
            end
            run--;
            rd_req = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
        end
        rd_req = 1'b0;
        cyc(4);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
